regfile_write_controller: RTL and testbench
===========================================

Name: regfile_write_controller

Overview:
- Write-back side of the 16-bit register file: drives the file's write_reg, write_data, r0 and reg_write inputs.
- Accepts results from the execute stage and the multi-cycle mul/div unit over a valid/ready handshake.
- Buffers results in a small FIFO and issues at most one register-file write per cycle.
- Reports whether a register has a write still pending, for hazard detection.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
CNT_W, 16, width of the issued-write counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
res_valid  input  1  result offered this cycle
res_ready  output  1  controller can accept a result
res_rd  input  4  destination register
res_lo  input  16  primary result (to res_rd)
res_hi  input  16  secondary result (to R0, mul high / div remainder)
res_kind  input  2  00 none, 01 single write, 10 dual write (rd + R0), 11 reserved
wb_hold  input  1  register file busy; freeze issue
flush  input  1  drop all queued, unissued entries
qry_reg  input  4  register to check for a pending write
qry_pending  output  1  qry_reg is the target of a queued entry
write_reg  output  4  to register file
write_data  output  16  to register file
r0  output  16  to register file R0 data
reg_write  output  2  00 none, 01 write write_data->write_reg, 10 also write r0->R0; 11 never driven
wr_count  output  CNT_W  number of issued writes, wraps
fifo_count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, async): FIFO empty, fifo_count=0, reg_write=00, write_reg=0, write_data=0, r0=0, wr_count=0, qry_pending=0, res_ready=1 once reset deasserts.
- Handshake: transfer when res_valid & res_ready on a rising edge. res_ready = (fifo_count < DEPTH) | issue_this_cycle, so a full FIFO still accepts when an entry drains the same cycle.
- res_kind 00 or 11: handshake completes, nothing enqueued. 11 is ignored silently.
- res_kind 10 with res_rd=0: enqueued as single write, write_reg=0, write_data=res_hi. R0 value wins.
- Issue:
  - Each cycle with FIFO non-empty and wb_hold=0, pop the head and register it onto the outputs.
  - The outputs are visible next cycle: write_reg=rd, write_data=lo, r0=hi for dual (0 for single).
  - reg_write=01 or 10 for exactly one cycle.
  - wr_count increments by 1 on each issue.
- Latency: a result accepted into an empty FIFO at edge N, with wb_hold=0, can issue no earlier than edge N+1. reg_write is nonzero after edge N+1; no bypass.
- Idle or wb_hold=1: reg_write=00; write_reg/write_data/r0 hold their last values. wb_hold asserted mid-stream stops further pops; the write already on the outputs is not repeated.
- Ordering: strict FIFO; back-to-back writes to the same register issue in arrival order.
- qry_pending (combinational):
  - 1 if any queued entry has rd==qry_reg.
  - 1 if qry_reg==0 and any queued entry is a dual write.
  - The entry currently on the outputs is not counted.
- flush: synchronous; empties the FIFO at the next edge. The write already on the outputs completes.
  - A simultaneous accept is dropped.
  - Flush has priority over issue: no pop that cycle, reg_write=00 next cycle.
- Simultaneous accept and issue: occupancy unchanged; the accepted entry goes to the tail.
- Pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH.
- Reset asserted mid-operation: all state cleared immediately, queued writes lost, reg_write forced to 00 asynchronously.

Test Plan:
- Reset, then send kind 01, rd=3, lo=16'hBEEF. Required: one cycle later reg_write=01, write_reg=3, write_data=BEEF; following cycle reg_write=00; wr_count=1.
- Send kind 10, rd=5, lo=1234, hi=ABCD. Required: reg_write=10, write_reg=5, write_data=1234, r0=ABCD.
- Send kind 10, rd=0, lo=1111, hi=2222. Required: reg_write=01, write_reg=0, write_data=2222.
- Hold wb_hold=1 and send 5 results with DEPTH=4. Required: res_ready=0 after 4; qry_reg=7 pending if any targets r7.
  - Then release wb_hold: writes issue in order on 4 consecutive cycles, the 5th is accepted, fifo_count returns to 0.
- Queue 3 entries under wb_hold, then assert flush with res_valid=1. Required: fifo_count=0 next cycle, no writes issued, qry_pending=0.
- Pulse reset low mid-issue with 2 queued. Required: reg_write=00 immediately, wr_count=0, queued writes never appear.

Source files
------------

// File: rtl/regfile_write_controller_if.sv
// Result handshake from the execute / mul-div side and the write bus
// into the 16-bit register file.
//   res_valid/res_ready : result transfer handshake
//   res_rd/res_lo/res_hi/res_kind : destination, primary/secondary data, write kind
//   write_reg/write_data/r0/reg_write : register-file write port
interface regfile_write_controller_if;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_rd;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic [1:0]  res_kind;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] r0;
  logic [1:0]  reg_write;

  modport master (
    output res_valid, res_rd, res_lo, res_hi, res_kind,
    input  res_ready, write_reg, write_data, r0, reg_write
  );

  modport slave (
    input  res_valid, res_rd, res_lo, res_hi, res_kind,
    output res_ready, write_reg, write_data, r0, reg_write
  );
endinterface

// File: rtl/regfile_write_controller.sv
// Write-back controller: buffers results in a DEPTH-entry FIFO and issues
// at most one register-file write per cycle, reporting pending writes.
//   clk, reset   : clock, asynchronous active-low reset
//   bus (slave)  : result handshake in, register-file write port out
//   wb_hold      : freeze issue
//   flush        : drop all queued entries (and any same-cycle accept)
//   qry_reg/qry_pending : pending-write query for hazard detection
//   wr_count     : issued-write counter (wraps)
//   fifo_count   : current occupancy
module regfile_write_controller #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_controller_if.slave bus,
  input  logic                      wb_hold,
  input  logic                      flush,
  input  logic [3:0]                qry_reg,
  output logic                      qry_pending,
  output logic [CNT_W-1:0]          wr_count,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [3:0]  rd_mem_q   [DEPTH];
  logic [15:0] lo_mem_q   [DEPTH];
  logic [15:0] hi_mem_q   [DEPTH];
  logic        dual_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic [3:0]       write_reg_q;
  logic [15:0]      write_data_q, r0_q;
  logic [1:0]       reg_write_q;
  logic [CNT_W-1:0] wr_count_q;

  logic          issue, accept, enq;
  logic          enq_dual;
  logic [15:0]   enq_lo;
  logic [AW-1:0] qoffs;

  assign issue         = (count_q != '0) && !wb_hold && !flush;
  assign bus.res_ready = (count_q < FULL) || issue;
  assign accept        = bus.res_valid && bus.res_ready;
  assign enq           = accept && !flush &&
                         ((bus.res_kind == 2'b01) || (bus.res_kind == 2'b10));

  // Dual write to R0 collapses to a single write carrying the R0 value.
  always_comb begin
    enq_dual = 1'b0;
    enq_lo   = bus.res_lo;
    if (bus.res_kind == 2'b10) begin
      if (bus.res_rd == 4'd0) enq_lo   = bus.res_hi;
      else                    enq_dual = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (enq && !issue)      count_d = count_q + 1'b1;
      else if (!enq && issue) count_d = count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem_q[wr_ptr_q]   <= bus.res_rd;
      lo_mem_q[wr_ptr_q]   <= enq_lo;
      hi_mem_q[wr_ptr_q]   <= bus.res_hi;
      dual_mem_q[wr_ptr_q] <= enq_dual;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      r0_q         <= '0;
      reg_write_q  <= '0;
      wr_count_q   <= '0;
    end else begin
      count_q     <= count_d;
      reg_write_q <= '0;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (issue) begin
          rd_ptr_q     <= rd_ptr_q + 1'b1;
          write_reg_q  <= rd_mem_q[rd_ptr_q];
          write_data_q <= lo_mem_q[rd_ptr_q];
          r0_q         <= dual_mem_q[rd_ptr_q] ? hi_mem_q[rd_ptr_q] : '0;
          reg_write_q  <= dual_mem_q[rd_ptr_q] ? 2'b10 : 2'b01;
          wr_count_q   <= wr_count_q + 1'b1;
        end
      end
    end
  end

  // A physical slot is live when its distance from the head is below occupancy.
  always_comb begin
    qry_pending = 1'b0;
    qoffs       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      qoffs = AW'(i) - rd_ptr_q;
      if (({1'b0, qoffs} < count_q) &&
          ((rd_mem_q[i] == qry_reg) || ((qry_reg == 4'd0) && dual_mem_q[i])))
        qry_pending = 1'b1;
    end
  end

  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.r0         = r0_q;
  assign bus.reg_write  = reg_write_q;
  assign wr_count       = wr_count_q;
  assign fifo_count     = count_q;
endmodule

// File: tb/tb_regfile_write_controller.sv
module tb_regfile_write_controller;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        wb_hold;
  logic        flush;
  logic [3:0]  qry_reg;
  logic        qry_pending;
  logic [15:0] wr_count;
  logic [2:0]  fifo_count;

  regfile_write_controller_if bus ();

  regfile_write_controller #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .wb_hold     (wb_hold),
    .flush       (flush),
    .qry_reg     (qry_reg),
    .qry_pending (qry_pending),
    .wr_count    (wr_count),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] d;
    logic [15:0] h;
    bit          dual;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  exp_rw;
  logic [3:0]  exp_wreg;
  logic [15:0] exp_wd, exp_r0, exp_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [1:0] k, logic [3:0] rd, logic [15:0] lo, logic [15:0] hi);
    bus.res_valid = v;
    bus.res_kind  = k;
    bus.res_rd    = rd;
    bus.res_lo    = lo;
    bus.res_hi    = hi;
  endtask

  task automatic model_clear();
    mq.delete();
    exp_rw = 2'b00; exp_wreg = '0; exp_wd = '0; exp_r0 = '0; exp_cnt = '0;
  endtask

  // Called just after an edge with inputs already driven; ends just after the next edge.
  task automatic cycle();
    bit   iss, rdy, pend;
    ent_t e;
    #1;
    iss  = (mq.size() > 0) && !wb_hold && !flush;
    rdy  = (mq.size() < DEPTH) || iss;
    pend = 0;
    foreach (mq[i])
      if (mq[i].rd == qry_reg || (qry_reg == 4'd0 && mq[i].dual)) pend = 1;
    chk("res_ready", bus.res_ready, rdy);
    chk("qry_pending", qry_pending, pend);
    if (flush) begin
      mq.delete();
      exp_rw = 2'b00;
    end else begin
      exp_rw = 2'b00;
      if (iss) begin
        e        = mq.pop_front();
        exp_rw   = e.dual ? 2'b10 : 2'b01;
        exp_wreg = e.rd;
        exp_wd   = e.d;
        exp_r0   = e.dual ? e.h : 16'h0;
        exp_cnt  = exp_cnt + 16'd1;
      end
      if (bus.res_valid && rdy && (bus.res_kind == 2'b01 || bus.res_kind == 2'b10)) begin
        e.rd   = bus.res_rd;
        e.h    = bus.res_hi;
        e.dual = (bus.res_kind == 2'b10) && (bus.res_rd != 4'd0);
        e.d    = (bus.res_kind == 2'b10 && bus.res_rd == 4'd0) ? bus.res_hi : bus.res_lo;
        mq.push_back(e);
      end
    end
    @(posedge clk); #1;
    chk("reg_write", bus.reg_write, exp_rw);
    chk("write_reg", bus.write_reg, exp_wreg);
    chk("write_data", bus.write_data, exp_wd);
    chk("r0", bus.r0, exp_r0);
    chk("wr_count", wr_count, exp_cnt);
    chk("fifo_count", fifo_count, mq.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; wb_hold = 1'b0; flush = 1'b0; qry_reg = 4'd0;
    drive(0, 2'b00, 4'd0, 16'h0, 16'h0);
    model_clear();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_reg_write", bus.reg_write, 2'b00);
    chk("rst_write_data", bus.write_data, 16'h0);
    chk("rst_wr_count", wr_count, 16'h0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_res_ready", bus.res_ready, 1'b1);
    chk("rst_qry_pending", qry_pending, 1'b0);

    // Single write, then idle.
    drive(1, 2'b01, 4'd3, 16'hBEEF, 16'h0);
    cycle();
    drive(0, 2'b00, 4'd0, 16'h0, 16'h0);
    cycle();
    chk("single_data", bus.write_data, 16'hBEEF);
    chk("single_kind", bus.reg_write, 2'b01);
    cycle();
    chk("single_done", wr_count, 16'd1);

    // Dual write, and dual write to R0 collapsing to a single write.
    drive(1, 2'b10, 4'd5, 16'h1234, 16'hABCD);
    cycle();
    drive(1, 2'b10, 4'd0, 16'h1111, 16'h2222);
    cycle();
    chk("dual_r0", bus.r0, 16'hABCD);
    drive(1, 2'b11, 4'd9, 16'h5555, 16'h6666);
    cycle();
    chk("r0_single_data", bus.write_data, 16'h2222);
    drive(0, 2'b00, 4'd0, 16'h0, 16'h0);
    repeat (2) cycle();

    // Fill under hold; fifth result must stall.
    wb_hold = 1'b1; qry_reg = 4'd7;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b01, 4'(6 + i), 16'(16'h100 + i), 16'h0);
      cycle();
    end
    chk("full_ready", bus.res_ready, 1'b0);
    chk("full_count", fifo_count, 3'd4);
    wb_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!bus.res_valid || bus.res_ready) drive(i == 0, 2'b01, 4'd10, 16'h0104, 16'h0);
      cycle();
    end
    drive(0, 2'b00, 4'd0, 16'h0, 16'h0);
    repeat (2) cycle();
    chk("drain_count", fifo_count, 3'd0);

    // Flush with a simultaneous offered result.
    wb_hold = 1'b1; qry_reg = 4'd2;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b01, 4'(i + 1), 16'(16'h200 + i), 16'h0);
      cycle();
    end
    flush = 1'b1;
    drive(1, 2'b01, 4'd2, 16'h0999, 16'h0);
    cycle();
    flush = 1'b0; wb_hold = 1'b0;
    drive(0, 2'b00, 4'd0, 16'h0, 16'h0);
    chk("flush_count", fifo_count, 3'd0);
    cycle();
    chk("flush_no_write", bus.reg_write, 2'b00);

    // Reset pulse mid-issue with entries still queued.
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, 4'(i + 4), 16'(16'h300 + i), 16'(16'h400 + i));
      cycle();
    end
    drive(0, 2'b00, 4'd0, 16'h0, 16'h0);
    wb_hold = 1'b0;
    cycle();
    reset = 1'b0;
    #1;
    chk("arst_reg_write", bus.reg_write, 2'b00);
    chk("arst_wr_count", wr_count, 16'h0);
    chk("arst_fifo_count", fifo_count, 3'd0);
    #2 reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    repeat (3) cycle();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      wb_hold = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 24) == 0);
      qry_reg = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            16'($urandom), 16'($urandom));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
